// File: rtl/nic_controller.sv
// Processor-side NIC: one-entry input/output channel buffers between the MEM stage
// and the on-chip router, with status registers and wrapping debug packet counters.
module nic_controller #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nic_en,
    input  logic              nic_wr_en,
    input  logic [1:0]        addr_nic,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  tx_count
);

    localparam logic [1:0] ADDR_IB_DATA = 2'b00;
    localparam logic [1:0] ADDR_IB_STAT = 2'b01;
    localparam logic [1:0] ADDR_OB_DATA = 2'b10;
    localparam logic [1:0] ADDR_OB_STAT = 2'b11;

    logic [DATA_W-1:0] ib_data_q, ib_data_d;
    logic              ib_full_q, ib_full_d;
    logic [DATA_W-1:0] ob_data_q, ob_data_d;
    logic              ob_full_q, ob_full_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;

    logic rd_access;
    logic wr_access;

    assign rd_access = nic_en & ~nic_wr_en;
    assign wr_access = nic_en & nic_wr_en;

    // Next-state for both channels, load data and counters; all decisions use pre-edge flags.
    always_comb begin
        ib_data_d  = ib_data_q;
        ib_full_d  = ib_full_q;
        ob_data_d  = ob_data_q;
        ob_full_d  = ob_full_q;
        d_out_d    = d_out_q;
        rx_count_d = rx_count_q;
        tx_count_d = tx_count_q;

        if (net_si && !ib_full_q) begin
            ib_data_d  = net_di;
            ib_full_d  = 1'b1;
            rx_count_d = rx_count_q + CNT_W'(1);
        end

        if (rd_access) begin
            case (addr_nic)
                ADDR_IB_DATA: begin
                    d_out_d = ib_data_q;
                    // Only a full buffer is drained; an empty read must not cancel a same-cycle capture.
                    if (ib_full_q) begin
                        ib_full_d = 1'b0;
                    end
                end
                ADDR_IB_STAT: d_out_d = DATA_W'(ib_full_q);
                ADDR_OB_DATA: d_out_d = '0;
                ADDR_OB_STAT: d_out_d = DATA_W'(ob_full_q);
                default:      d_out_d = d_out_q;
            endcase
        end

        // A store into a full output buffer is dropped even if the router drains it this edge.
        if (wr_access && (addr_nic == ADDR_OB_DATA) && !ob_full_q) begin
            ob_data_d = d_in;
            ob_full_d = 1'b1;
        end

        if (ob_full_q && net_ro) begin
            ob_full_d  = 1'b0;
            tx_count_d = tx_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ib_data_q  <= '0;
            ib_full_q  <= 1'b0;
            ob_data_q  <= '0;
            ob_full_q  <= 1'b0;
            d_out_q    <= '0;
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            ib_data_q  <= ib_data_d;
            ib_full_q  <= ib_full_d;
            ob_data_q  <= ob_data_d;
            ob_full_q  <= ob_full_d;
            d_out_q    <= d_out_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign d_out    = d_out_q;
    assign net_ri   = ~ib_full_q;
    assign net_so   = ob_full_q;
    assign net_do   = ob_data_q;
    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_nic_controller.sv
// Directed vector bench for nic_controller: a table of per-cycle stimulus with expected
// post-edge outputs, plus a counter-wrap sequence on a narrow-counter instance.
module tb_nic_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nic_en, nic_wr_en;
    logic [1:0]  addr_nic;
    logic [63:0] d_in, d_out, net_di, net_do;
    logic        net_si, net_ri, net_so, net_ro;
    logic [15:0] rx_count, tx_count;

    logic        w_rst_n, w_en, w_wr, w_si, w_ri, w_so, w_ro;
    logic [1:0]  w_addr;
    logic [63:0] w_din, w_dout, w_di, w_do;
    logic [3:0]  w_rx, w_tx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nic_controller #(.DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
        .addr_nic(addr_nic), .d_in(d_in), .d_out(d_out),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    nic_controller #(.DATA_W(64), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .nic_en(w_en), .nic_wr_en(w_wr),
        .addr_nic(w_addr), .d_in(w_din), .d_out(w_dout),
        .net_si(w_si), .net_ri(w_ri), .net_di(w_di),
        .net_so(w_so), .net_ro(w_ro), .net_do(w_do),
        .rx_count(w_rx), .tx_count(w_tx)
    );

    typedef struct {
        logic        rst_n, en, wr;
        logic [1:0]  addr;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic [63:0] e_dout;
        logic        e_ri, e_so;
        logic [63:0] e_do;
        logic [15:0] e_rx, e_tx;
    } vec_t;

    localparam int unsigned NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic en, logic wr, logic [1:0] a, logic [63:0] din,
                                logic si, logic [63:0] di, logic ro, logic [63:0] e_dout,
                                logic e_ri, logic e_so, logic [63:0] e_do,
                                logic [15:0] e_rx, logic [15:0] e_tx);
        vec_t v;
        v.rst_n = r; v.en = en; v.wr = wr; v.addr = a; v.din = din;
        v.si = si; v.di = di; v.ro = ro; v.e_dout = e_dout;
        v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do; v.e_rx = e_rx; v.e_tx = e_tx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [63:0] PK1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PKA = 64'h0000_0000_0000_AAAA;
    localparam logic [63:0] PKB = 64'h0000_0000_0000_BBBB;

    initial begin
        // rst en wr addr din si di ro | d_out ri so net_do rx tx
        vecs[0]  = mk(0,1,0,2'd0,64'h0,     1,PK1,0, 64'h0,   1,0,64'h0,   0,0);
        vecs[1]  = mk(0,1,0,2'd0,64'h0,     1,PK1,0, 64'h0,   1,0,64'h0,   0,0);
        vecs[2]  = mk(1,0,0,2'd0,64'h0,     0,64'h0,0, 64'h0, 1,0,64'h0,   0,0);
        vecs[3]  = mk(1,0,0,2'd0,64'h0,     1,PK1,0, 64'h0,   0,0,64'h0,   1,0);
        vecs[4]  = mk(1,1,0,2'd1,64'h0,     1,PKA,0, 64'h1,   0,0,64'h0,   1,0);
        vecs[5]  = mk(1,1,0,2'd0,64'h0,     1,PKA,0, PK1,     1,0,64'h0,   1,0);
        vecs[6]  = mk(1,1,0,2'd3,64'h0,     1,PKA,0, 64'h0,   0,0,64'h0,   2,0);
        vecs[7]  = mk(1,1,0,2'd0,64'h0,     0,64'h0,0, PKA,   1,0,64'h0,   2,0);
        vecs[8]  = mk(1,1,0,2'd0,64'h0,     0,64'h0,0, PKA,   1,0,64'h0,   2,0);
        vecs[9]  = mk(1,1,0,2'd2,64'h0,     0,64'h0,0, 64'h0, 1,0,64'h0,   2,0);
        vecs[10] = mk(1,1,1,2'd2,64'h1234,  0,64'h0,0, 64'h0, 1,1,64'h1234,2,0);
        vecs[11] = mk(1,1,0,2'd3,64'h0,     0,64'h0,0, 64'h1, 1,1,64'h1234,2,0);
        vecs[12] = mk(1,1,1,2'd2,64'h5678,  0,64'h0,0, 64'h1, 1,1,64'h1234,2,0);
        vecs[13] = mk(1,1,1,2'd0,64'h9999,  0,64'h0,0, 64'h1, 1,1,64'h1234,2,0);
        vecs[14] = mk(1,0,0,2'd0,64'h0,     0,64'h0,1, 64'h1, 1,0,64'h1234,2,1);
        vecs[15] = mk(1,1,1,2'd2,64'h5678,  0,64'h0,1, 64'h1, 1,1,64'h5678,2,1);
        vecs[16] = mk(1,1,1,2'd2,64'h9ABC,  0,64'h0,1, 64'h1, 1,0,64'h5678,2,2);
        vecs[17] = mk(1,1,0,2'd3,64'h0,     0,64'h0,0, 64'h0, 1,0,64'h5678,2,2);
        vecs[18] = mk(1,1,1,2'd2,64'h1111,  1,PKB,0, 64'h0,   0,1,64'h1111,3,2);
        vecs[19] = mk(0,1,0,2'd0,64'h0,     1,PKA,1, 64'h0,   1,0,64'h0,   0,0);
        vecs[20] = mk(1,0,0,2'd0,64'h0,     0,64'h0,0, 64'h0, 1,0,64'h0,   0,0);

        w_rst_n = 1'b0; w_en = 1'b0; w_wr = 1'b0; w_addr = 2'd0;
        w_din = 64'h0; w_si = 1'b0; w_di = 64'h0; w_ro = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            rst_n     = vecs[i].rst_n;
            nic_en    = vecs[i].en;
            nic_wr_en = vecs[i].wr;
            addr_nic  = vecs[i].addr;
            d_in      = vecs[i].din;
            net_si    = vecs[i].si;
            net_di    = vecs[i].di;
            net_ro    = vecs[i].ro;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d d_out", i),    d_out,             vecs[i].e_dout);
            chk($sformatf("v%0d net_ri", i),   64'(net_ri),       64'(vecs[i].e_ri));
            chk($sformatf("v%0d net_so", i),   64'(net_so),       64'(vecs[i].e_so));
            chk($sformatf("v%0d net_do", i),   net_do,            vecs[i].e_do);
            chk($sformatf("v%0d rx_count", i), 64'(rx_count),     64'(vecs[i].e_rx));
            chk($sformatf("v%0d tx_count", i), 64'(tx_count),     64'(vecs[i].e_tx));
        end

        // Counter wrap on a 4-bit-counter instance: each iteration moves one packet each way.
        @(posedge clk); #1;
        w_rst_n = 1'b1;
        w_ro    = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            w_si = 1'b1; w_di = 64'(k); w_en = 1'b1; w_wr = 1'b1; w_addr = 2'd2; w_din = 64'(k);
            @(posedge clk); #1;
            w_si = 1'b0; w_en = 1'b1; w_wr = 1'b0; w_addr = 2'd0;
            @(posedge clk); #1;
            chk($sformatf("wrap%0d d_out", k), w_dout, 64'(k));
            if (k == 15 || k == 16) begin
                chk($sformatf("wrap%0d rx_count", k), 64'(w_rx), 64'(k % 16));
                chk($sformatf("wrap%0d tx_count", k), 64'(w_tx), 64'(k % 16));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nic_controller.md
# nic_controller

Processor-side network interface controller for the pipelined core. It arbitrates the single NIC resource between the MEM stage and the on-chip router, using one-entry input and output channel buffers with status flags and valid/ready handshakes. The MEM stage addresses it through `nic_en`, `nic_wr_en` and `addr_nic`, which are produced for LD/SD instructions whose address has bits [15:14] = 11. Read data returns to the WB path one cycle later.

## Interface
- DATA_W, 64, width of packet and processor data
- CNT_W, 16, width of the debug packet counters
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- nic_en  in  1  NIC access this cycle (MEM stage)
- nic_wr_en  in  1  1 = store (SD), 0 = load (LD); valid only with nic_en
- addr_nic  in  2  register select: 00 input buffer (R), 01 input status (R), 10 output buffer (W), 11 output status (R)
- d_in  in  DATA_W  store data from register file
- d_out  out  DATA_W  registered load data
- net_si  in  1  router presents a packet to the input channel
- net_ri  out  1  input channel ready (= ~ib_full)
- net_di  in  DATA_W  incoming packet
- net_so  out  1  output channel valid (= ob_full)
- net_ro  in  1  router ready for the outgoing packet
- net_do  out  DATA_W  outgoing packet (= ob_data)
- rx_count  out  CNT_W  packets accepted from the router, wrapping
- tx_count  out  CNT_W  packets delivered to the router, wrapping

## Operation
- State: ib_data/ib_full (input channel), ob_data/ob_full (output channel), d_out, rx_count, tx_count.
- Input capture: net_si & net_ri at an edge -> ib_data <= net_di, ib_full <= 1, rx_count += 1.
- Input drain: nic_en & ~nic_wr_en & addr_nic=00 -> d_out <= ib_data, ib_full <= 0. If ib_full=0, d_out <= stale ib_data and flags are unchanged.
- Because net_ri = ~ib_full, a capture and a drain never occur in the same cycle.
- Input status read (01): d_out <= {zeros, ib_full} (pre-edge value).
- Output status read (11): d_out <= {zeros, ob_full} (pre-edge value).
- Read of 10: d_out <= 0.
- Output write: nic_en & nic_wr_en & addr_nic=10 & ob_full=0 (pre-edge) -> ob_data <= d_in, ob_full <= 1.
- Write while ob_full=1 is dropped, even if the drain happens in the same cycle. Software must poll status 11 before storing.
- Writes to 00/01/11 are ignored.
- Output drain: net_so & net_ro at an edge -> ob_full <= 0, tx_count += 1. ob_data holds its value.
- Without a read access, d_out holds its value.
- Counters wrap from 2^CNT_W-1 to 0.
- Reset (rst_n=0 at an edge): ib_full, ob_full, ib_data, ob_data, d_out, rx_count and tx_count all go to 0. Reset dominates every concurrent access or handshake.
- Outputs after reset: net_ri=1, net_so=0, net_do=0, d_out=0.
- Reset mid-operation discards buffered packets; no handshake completes on the reset edge.

## Timing
- Load latency: access in cycle N -> d_out valid in cycle N+1, held until the next read.
- Input channel: capture at edge E -> net_ri=0 from E. A drain at edge F -> net_ri=1 from F, so the earliest next capture is F+1 edge. Peak rate is 1 packet per 2 cycles per channel.
- Output channel: write at edge E -> net_so=1 from E. The router completes at the first edge with net_ro=1. The earliest next accepted write is at the edge after the drain.
- net_ri, net_so and net_do depend only on flops; there is no combinational path from any input.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with net_si=1 and nic_en=1 -> after release, net_ri=1, net_so=0, d_out=0, rx_count=tx_count=0, nothing captured.
- Receive: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one edge -> net_ri=0. Read 01 -> d_out=1. Read 00 -> d_out=64'hDEAD_BEEF_0000_0001 next cycle, then net_ri=1, rx_count=1.
- Receive backpressure: second packet offered while ib_full=1 -> not captured, ib_data unchanged; it is captured the cycle after the drain.
- Send: SD d_in=64'h1234 to 10 with net_ro=0 -> net_so=1, net_do=64'h1234. A second SD of 64'h5678 is dropped. Raise net_ro -> net_so=0 after one edge, tx_count=1, net_do stays 64'h1234.
- Simultaneous: ob_full=1, SD to 10 and net_ro=1 at the same edge -> drain happens, write dropped, ob_full=0.
- Wrap: preload rx_count to 16'hFFFF via 65535 receives (or force), one more receive -> rx_count=0.
